// File: rtl/region_table_writer_if.sv
// region_table_writer_if: host byte stream, region RAM write ports and frame status
interface region_table_writer_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        region0_wren;
    logic [9:0]  region0_wraddr;
    logic [17:0] region0_wrdata;
    logic        region1_wren;
    logic [9:0]  region1_wraddr;
    logic [17:0] region1_wrdata;
    logic        region2_wren;
    logic [9:0]  region2_wraddr;
    logic [17:0] region2_wrdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  err_code;
    modport master (
        output in_valid, in_data,
        input  in_ready, region0_wren, region0_wraddr, region0_wrdata,
        input  region1_wren, region1_wraddr, region1_wrdata,
        input  region2_wren, region2_wraddr, region2_wrdata,
        input  busy, done, err, err_code
    );
    modport slave (
        input  in_valid, in_data,
        output in_ready, region0_wren, region0_wraddr, region0_wrdata,
        output region1_wren, region1_wraddr, region1_wrdata,
        output region2_wren, region2_wraddr, region2_wrdata,
        output busy, done, err, err_code
    );
endinterface

// File: rtl/region_table_writer.sv
// region_table_writer: parses host command frames and writes the inner/middle/outer region RAMs
module region_table_writer #(
    parameter int          REGION_POINTS = 812,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter logic [17:0] FILL_VALUE    = 18'h0FFFF,
    parameter int          TIMEOUT       = 100000
) (
    input logic                  clk,
    input logic                  rst,
    region_table_writer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [3:0] {
        S_HUNT, S_CMD, S_REG, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L,
        S_DATA_H, S_DATA_L, S_CHK, S_CLEAR
    } state_t;
    state_t        r_state, w_next;
    logic          w_acc, w_tmo, w_range_bad, w_err, w_done, w_wr;
    logic [2:0]    w_code, r_err_code;
    logic [9:0]    w_wa, r_clr;
    logic [17:0]   w_wd;
    logic [15:0]   r_addr, r_cnt, w_cnt;
    logic [7:0]    r_hi, r_chk;
    logic [1:0]    r_reg;
    logic          r_is_clr, r_done, r_err;
    logic [TW-1:0] r_tmo;
    logic [2:0]    r_wren;
    logic [9:0]    r_wraddr [3];
    logic [17:0]   r_wrdata [3];
    assign bus.in_ready = r_state != S_CLEAR;
    assign bus.busy     = r_state != S_HUNT;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.err_code = r_err_code;
    assign bus.region0_wren   = r_wren[0];
    assign bus.region0_wraddr = r_wraddr[0];
    assign bus.region0_wrdata = r_wrdata[0];
    assign bus.region1_wren   = r_wren[1];
    assign bus.region1_wraddr = r_wraddr[1];
    assign bus.region1_wrdata = r_wrdata[1];
    assign bus.region2_wren   = r_wren[2];
    assign bus.region2_wraddr = r_wraddr[2];
    assign bus.region2_wrdata = r_wrdata[2];
    assign w_acc       = bus.in_valid && bus.in_ready;
    assign w_cnt       = {r_cnt[15:8], bus.in_data};
    assign w_range_bad = w_cnt == 16'd0 || ({1'b0, r_addr} + {1'b0, w_cnt}) > 17'(REGION_POINTS);
    assign w_tmo       = r_state != S_HUNT && r_state != S_CLEAR && !w_acc && r_tmo == TW'(TIMEOUT - 1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_HUNT;
        else     r_state <= w_next;
    end

    // Next state, write request and status pulses for the current byte or fill step
    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        w_code = 3'd0;
        w_done = 1'b0;
        w_wr   = 1'b0;
        w_wa   = r_addr[9:0];
        w_wd   = {2'b00, r_hi, bus.in_data};
        if (r_state == S_CLEAR) begin
            w_wr = 1'b1;
            w_wa = r_clr;
            w_wd = FILL_VALUE;
            if (r_clr == 10'(REGION_POINTS - 1)) begin
                w_done = 1'b1;
                w_next = S_HUNT;
            end
        end else if (w_tmo) begin
            w_err  = 1'b1;
            w_code = 3'd5;
        end else if (w_acc) begin
            case (r_state)
                S_HUNT:   w_next = bus.in_data == SYNC_BYTE ? S_CMD : S_HUNT;
                S_CMD: begin
                    w_next = S_REG;
                    w_err  = bus.in_data != 8'h01 && bus.in_data != 8'h02;
                    w_code = 3'd1;
                end
                S_REG: begin
                    w_next = S_ADDR_H;
                    w_err  = bus.in_data > 8'd2;
                    w_code = 3'd2;
                end
                S_ADDR_H: w_next = S_ADDR_L;
                S_ADDR_L: w_next = S_CNT_H;
                S_CNT_H:  w_next = S_CNT_L;
                S_CNT_L: begin
                    w_next = r_is_clr ? S_CHK : S_DATA_H;
                    w_err  = !r_is_clr && w_range_bad;
                    w_code = 3'd3;
                end
                S_DATA_H: w_next = S_DATA_L;
                S_DATA_L: begin
                    w_wr   = 1'b1;
                    w_next = r_cnt == 16'd1 ? S_CHK : S_DATA_H;
                end
                S_CHK: begin
                    w_err  = bus.in_data != r_chk;
                    w_code = 3'd4;
                    w_done = !w_err && !r_is_clr;
                    w_next = r_is_clr ? S_CLEAR : S_HUNT;
                end
                default: w_next = S_HUNT;
            endcase
        end
        if (w_err) w_next = S_HUNT;
    end

    // Frame fields, checksum, timers and registered RAM/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_code <= 3'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= 16'd0;
            r_cnt      <= 16'd0;
            r_hi       <= 8'd0;
            r_chk      <= 8'd0;
            r_reg      <= 2'd0;
            r_is_clr   <= 1'b0;
            r_clr      <= 10'd0;
            r_tmo      <= '0;
            r_wren     <= 3'd0;
            for (int i = 0; i < 3; i++) begin
                r_wraddr[i] <= 10'd0;
                r_wrdata[i] <= 18'd0;
            end
        end else begin
            r_done <= w_done;
            r_err  <= w_err;
            if (w_err) r_err_code <= w_code;
            for (int i = 0; i < 3; i++) begin
                r_wren[i] <= w_wr && r_reg == 2'(i);
                if (w_wr && r_reg == 2'(i)) begin
                    r_wraddr[i] <= w_wa;
                    r_wrdata[i] <= w_wd;
                end
            end
            r_tmo <= (w_acc || r_state == S_HUNT || r_state == S_CLEAR) ? '0 : r_tmo + TW'(1);
            r_clr <= r_state == S_CLEAR ? r_clr + 10'd1 : 10'd0;
            if (w_acc) begin
                r_chk <= r_state == S_HUNT ? 8'd0 : r_chk ^ bus.in_data;
                case (r_state)
                    S_CMD:    r_is_clr <= bus.in_data == 8'h02;
                    S_REG:    r_reg <= bus.in_data[1:0];
                    S_ADDR_H: r_addr[15:8] <= bus.in_data;
                    S_ADDR_L: r_addr[7:0] <= bus.in_data;
                    S_CNT_H:  r_cnt[15:8] <= bus.in_data;
                    S_CNT_L:  r_cnt[7:0] <= bus.in_data;
                    S_DATA_H: r_hi <= bus.in_data;
                    S_DATA_L: begin
                        r_addr <= r_addr + 16'd1;
                        r_cnt  <= r_cnt - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_region_table_writer.sv
// tb_region_table_writer: frame vectors, corner sequences and random frames against a frame-level model
module tb_region_table_writer;
    localparam int TMO  = 64;
    localparam int NPTS = 812;
    localparam int NT   = 10;
    typedef logic [7:0] bq_t[$];
    typedef struct { int r; int a; int d; } wr_t;
    typedef struct {
        int cmd, rg, addr, cnt, w0, w1, w2, nb, cm;
        int xd, xe, xc, nw, xr, fa, fd, la, ld;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0, checks = 0;
    int   done_cnt = 0, err_cnt = 0, low_cnt = 0, done_at = 0;
    bit   multi = 1'b0;
    wr_t  wq[$];
    int   d0, e0, w0, l0, last_code, k, bad;
    vec_t t [NT];
    wr_t  ex[$];
    bq_t  f;
    logic [95:0] exp_rst;

    always #5 clk = ~clk;

    region_table_writer_if ifc();
    region_table_writer #(.TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(ifc));

    // Record every RAM write and status pulse seen mid-cycle
    always @(negedge clk) begin
        if (ifc.region0_wren) wq.push_back(wr_t'{0, int'(ifc.region0_wraddr), int'(ifc.region0_wrdata)});
        if (ifc.region1_wren) wq.push_back(wr_t'{1, int'(ifc.region1_wraddr), int'(ifc.region1_wrdata)});
        if (ifc.region2_wren) wq.push_back(wr_t'{2, int'(ifc.region2_wraddr), int'(ifc.region2_wrdata)});
        if (int'(ifc.region0_wren) + int'(ifc.region1_wren) + int'(ifc.region2_wren) > 1) multi = 1'b1;
        if (!ifc.in_ready) low_cnt++;
        if (ifc.done) begin
            done_cnt++;
            done_at = wq.size();
        end
        if (ifc.err) err_cnt++;
    end

    function automatic logic [95:0] outs();
        return {2'b00, ifc.in_ready, ifc.busy, ifc.done, ifc.err, ifc.err_code,
                ifc.region0_wren, ifc.region1_wren, ifc.region2_wren,
                ifc.region0_wraddr, ifc.region1_wraddr, ifc.region2_wraddr,
                ifc.region0_wrdata, ifc.region1_wrdata, ifc.region2_wrdata};
    endfunction

    function automatic bq_t build(input int cmd, rg, addr, cnt, w0_, w1_, w2_, w3_, nb, cm);
        bq_t         q;
        logic [7:0]  x;
        logic [15:0] a, c;
        logic [15:0] w [4];
        a = 16'(addr);
        c = 16'(cnt);
        w[0] = 16'(w0_);
        w[1] = 16'(w1_);
        w[2] = 16'(w2_);
        w[3] = 16'(w3_);
        q.push_back(8'hA5);
        q.push_back(8'(cmd));
        q.push_back(8'(rg));
        q.push_back(a[15:8]);
        q.push_back(a[7:0]);
        q.push_back(c[15:8]);
        q.push_back(c[7:0]);
        for (int i = 0; i < 4; i++) begin
            q.push_back(w[i][15:8]);
            q.push_back(w[i][7:0]);
        end
        while (q.size() > nb + 1) void'(q.pop_back());
        x = 8'd0;
        for (int i = 1; i < q.size(); i++) x ^= q[i];
        if (cm == 1) q.push_back(x);
        else if (cm == 2) q.push_back(~x);
        return q;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        while (!ifc.in_ready && n < 2000) begin @(posedge clk); #1; n++; end
        if (n >= 2000) chk("send_ready_timeout", 0, 1);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic send_all(input bq_t q, input int maxgap);
        foreach (q[i]) send(q[i], int'($urandom_range(0, maxgap)));
    endtask

    task automatic wait_end(input int dd, input int ee);
        int n = 0;
        while (done_cnt == dd && err_cnt == ee && n < 1500) begin @(posedge clk); #1; n++; end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic snap();
        d0 = done_cnt;
        e0 = err_cnt;
        w0 = wq.size();
        l0 = low_cnt;
    endtask

    initial begin
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'd0;
        exp_rst = 96'd0;
        exp_rst[93] = 1'b1;
        last_code = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chkv("reset_state", outs(), exp_rst);
        @(posedge clk); #1;
        //        cmd rg addr cnt  w0       w1       w2      nb cm  xd xe xc  nw  xr fa   fd       la   ld
        t[0] = '{1, 1, 10,    2,      'h1234, 'h0567, 0,      10, 1,  1, 0, 0,  2,   1, 10,  'h1234, 11,  'h0567};
        t[1] = '{2, 2, 0,     0,      0,      0,      0,      6,  1,  1, 0, 0,  812, 2, 0,   'hFFFF, 811, 'hFFFF};
        t[2] = '{1, 0, 810,   3,      0,      0,      0,      6,  0,  0, 1, 3,  0,   0, 0,   0,      0,   0};
        t[3] = '{1, 0, 809,   3,      'hA5A5, 'h00A5, 'hFFFF, 12, 1,  1, 0, 0,  3,   0, 809, 'hA5A5, 811, 'hFFFF};
        t[4] = '{1, 2, 100,   2,      'hBEEF, 1,      0,      10, 2,  0, 1, 4,  2,   2, 100, 'hBEEF, 101, 1};
        t[5] = '{1, 3, 0,     0,      0,      0,      0,      2,  0,  0, 1, 2,  0,   0, 0,   0,      0,   0};
        t[6] = '{7, 0, 0,     0,      0,      0,      0,      1,  0,  0, 1, 1,  0,   0, 0,   0,      0,   0};
        t[7] = '{1, 0, 5,     0,      0,      0,      0,      6,  0,  0, 1, 3,  0,   0, 0,   0,      0,   0};
        t[8] = '{2, 0, 'h1234,'hFFFF, 0,      0,      0,      6,  1,  1, 0, 0,  812, 0, 0,   'hFFFF, 811, 'hFFFF};
        t[9] = '{1, 1, 811,   1,      'h7E81, 0,      0,      8,  1,  1, 0, 0,  1,   1, 811, 'h7E81, 811, 'h7E81};
        for (int i = 0; i < NT; i++) begin
            snap();
            f = build(t[i].cmd, t[i].rg, t[i].addr, t[i].cnt, t[i].w0, t[i].w1, t[i].w2, 0, t[i].nb, t[i].cm);
            send_all(f, 1);
            wait_end(d0, e0);
            chk($sformatf("t%0d_done", i), done_cnt - d0, t[i].xd);
            chk($sformatf("t%0d_err", i), err_cnt - e0, t[i].xe);
            chk($sformatf("t%0d_code", i), int'(ifc.err_code), t[i].xe != 0 ? t[i].xc : last_code);
            if (t[i].xe != 0) last_code = t[i].xc;
            chk($sformatf("t%0d_nwr", i), wq.size() - w0, t[i].nw);
            if (wq.size() > w0) begin
                bad = 0;
                for (int j = w0; j < wq.size(); j++) if (wq[j].r != t[i].xr) bad++;
                chk($sformatf("t%0d_region", i), bad, 0);
                chk($sformatf("t%0d_first_addr", i), wq[w0].a, t[i].fa);
                chk($sformatf("t%0d_first_data", i), wq[w0].d, t[i].fd);
                chk($sformatf("t%0d_last_addr", i), wq[$].a, t[i].la);
                chk($sformatf("t%0d_last_data", i), wq[$].d, t[i].ld);
            end
            if (t[i].xd != 0) chk($sformatf("t%0d_done_after_writes", i), done_at - w0, t[i].nw);
            if (t[i].cmd == 2) chk($sformatf("t%0d_ready_low", i), low_cnt - l0, NPTS);
        end
        snap();
        send_all(build(1, 0, 0, 4, 0, 0, 0, 0, 3, 0), 0);
        chk("tmo_busy", int'(ifc.busy), 1);
        k = 0;
        while (err_cnt == e0 && k < TMO + 20) begin @(posedge clk); #1; k++; end
        chk("tmo_cycles_in_window", int'(k >= TMO && k <= TMO + 2), 1);
        chk("tmo_code", int'(ifc.err_code), 5);
        chk("tmo_busy_drop", int'(ifc.busy), 0);
        chk("tmo_no_done", done_cnt - d0, 0);
        snap();
        send_all(build(1, 1, 200, 4, 'h1111, 'h2222, 0, 0, 8, 0), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chkv("mid_frame_reset", outs(), exp_rst);
        chk("mid_frame_kept_write", wq.size() - w0, 1);
        @(posedge clk); #1;
        snap();
        send(8'h00, 0);
        send(8'hFF, 0);
        send_all(build(1, 0, 5, 1, 'h0042, 0, 0, 0, 8, 1), 0);
        wait_end(d0, e0);
        chk("garbage_done", done_cnt - d0, 1);
        chk("garbage_err", err_cnt - e0, 0);
        chk("garbage_nwr", wq.size() - w0, 1);
        if (wq.size() > w0) chk("garbage_write", int'(wq[w0].r == 0 && wq[w0].a == 5 && wq[w0].d == 'h42), 1);
        last_code = 0;
        for (int n = 0; n < 40; n++) begin
            int rg, cnt, addr, xb, nb, cm, xd, xe, xc;
            int w [4];
            rg   = int'($urandom_range(0, 2));
            cnt  = int'($urandom_range(0, 4));
            addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(805, NPTS - 1)) : int'($urandom_range(0, NPTS - 1));
            xb   = int'($urandom_range(0, 4) == 0);
            for (int j = 0; j < 4; j++) w[j] = int'($urandom_range(0, 65535));
            ex.delete();
            if (cnt == 0 || addr + cnt > NPTS) begin
                nb = 6; cm = 0; xd = 0; xe = 1; xc = 3;
            end else begin
                for (int j = 0; j < cnt; j++) ex.push_back(wr_t'{rg, addr + j, w[j]});
                nb = 6 + 2 * cnt; cm = xb != 0 ? 2 : 1;
                xd = xb != 0 ? 0 : 1; xe = xb; xc = 4;
            end
            snap();
            send_all(build(1, rg, addr, cnt, w[0], w[1], w[2], w[3], nb, cm), 2);
            wait_end(d0, e0);
            chk($sformatf("rnd%0d_done", n), done_cnt - d0, xd);
            chk($sformatf("rnd%0d_err", n), err_cnt - e0, xe);
            if (xe != 0) chk($sformatf("rnd%0d_code", n), int'(ifc.err_code), xc);
            chk($sformatf("rnd%0d_nwr", n), wq.size() - w0, ex.size());
            bad = 0;
            for (int j = 0; j < ex.size() && w0 + j < wq.size(); j++)
                if (wq[w0 + j] != ex[j]) bad++;
            chk($sformatf("rnd%0d_writes", n), bad, 0);
        end
        chk("single_region_wren", int'(multi), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
